// File: rtl/gf_pkg.sv
// +----------------------------------------------------------------------------+
// | gf_pkg                                                                      |
// | GF(2^m) field constants and arithmetic helpers for the RS decoder.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package gf_pkg;

   localparam int                  SYMB_WIDTH = 8;
   localparam int                  T_LEN      = 8;
   localparam logic [SYMB_WIDTH:0] PRIM_POLY  = 9'h11D;
   localparam int                  GF_ORDER   = (1 << SYMB_WIDTH) - 1;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_SEARCH = 1'b1
   } chien_state_t;

   function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                     input logic [SYMB_WIDTH-1:0] b);
      logic [SYMB_WIDTH-1:0] acc;
      logic [SYMB_WIDTH-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < SYMB_WIDTH; i++) begin
         if (b[i]) acc = acc ^ sh;
         if (sh[SYMB_WIDTH-1]) sh = {sh[SYMB_WIDTH-2:0], 1'b0} ^ PRIM_POLY[SYMB_WIDTH-1:0];
         else                  sh = {sh[SYMB_WIDTH-2:0], 1'b0};
      end
      return acc;
   endfunction

   // Exponent is reduced mod 2^m-1 first, so negative exponents give inverses.
   function automatic logic [SYMB_WIDTH-1:0] gf_alpha_pow(input int e);
      int                    r;
      logic [SYMB_WIDTH-1:0] p;
      logic [SYMB_WIDTH-1:0] alpha;
      r = e % GF_ORDER;
      if (r < 0) r = r + GF_ORDER;
      alpha = {{(SYMB_WIDTH-2){1'b0}}, 2'b10};
      p     = {{(SYMB_WIDTH-1){1'b0}}, 1'b1};
      for (int i = 0; i < GF_ORDER; i++) begin
         if (i < r) p = gf_mult(p, alpha);
      end
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gf_poly_eval.sv
// +----------------------------------------------------------------------------+
// | gf_poly_eval                                                                |
// | Combinational Horner evaluation of a GF(2^m) polynomial at one point.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf_poly_eval #(
   parameter int T_LEN      = gf_pkg::T_LEN,
   parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH
) (
   input  logic [T_LEN:0][SYMB_WIDTH-1:0] coeff_i,
   input  logic [SYMB_WIDTH-1:0]          x_i,
   output logic [SYMB_WIDTH-1:0]          val_o
);

   logic [SYMB_WIDTH-1:0] w_acc;

   always_comb begin
      w_acc = coeff_i[T_LEN];
      for (int i = T_LEN - 1; i >= 0; i--) begin
         w_acc = gf_pkg::gf_mult(w_acc, x_i) ^ coeff_i[i];
      end
      val_o = w_acc;
   end

endmodule

`default_nettype wire

// File: rtl/rs_chien_seq.sv
// +----------------------------------------------------------------------------+
// | rs_chien_seq                                                                |
// | Sequential Chien search: sweeps all codeword positions, P roots per beat,   |
// | streaming error flags plus root count / failure on the last beat.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs_chien_seq #(
   parameter int ROOTS_PER_CYCLE = 8,
   parameter int N_LEN           = 255,
   parameter int T_LEN           = gf_pkg::T_LEN,
   parameter int SYMB_WIDTH      = gf_pkg::SYMB_WIDTH
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [T_LEN:0][SYMB_WIDTH-1:0] error_locator,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic                           m_sop,
   output logic                           m_eop,
   output logic [ROOTS_PER_CYCLE-1:0]     error_bit_pos,
   output logic [$clog2(N_LEN+1)-1:0]     err_cnt,
   output logic                           fail
);

   localparam int c_NB         = (N_LEN + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE;
   localparam int c_BW         = (c_NB > 1) ? $clog2(c_NB) : 1;
   localparam int c_CW         = $clog2(N_LEN + 1);
   localparam int c_LAST_LANES = N_LEN - (c_NB - 1) * ROOTS_PER_CYCLE;
   localparam logic [c_BW-1:0]       c_LAST_BEAT = c_BW'(c_NB - 1);
   localparam logic [SYMB_WIDTH-1:0] c_STEP      = gf_pkg::gf_alpha_pow(-ROOTS_PER_CYCLE);

   gf_pkg::chien_state_t              state_q;
   logic                              s_ready_q;
   logic [T_LEN:0][SYMB_WIDTH-1:0]    lambda_q;
   logic [c_CW-1:0]                   deg_q;
   logic [c_BW-1:0]                   beat_q;
   logic [c_CW-1:0]                   cnt_q;
   logic                              m_valid_q;
   logic                              m_sop_q;
   logic                              m_eop_q;
   logic [ROOTS_PER_CYCLE-1:0]        bits_q;
   logic [c_CW-1:0]                   err_cnt_q;
   logic                              fail_q;

   logic                              w_accept;
   logic                              w_fire;
   logic                              w_last;
   logic [ROOTS_PER_CYCLE-1:0]        w_hit;
   logic [c_CW-1:0]                   w_pop;
   logic [c_CW-1:0]                   w_cnt_sum;

   function automatic logic [c_CW-1:0] f_degree(input logic [T_LEN:0][SYMB_WIDTH-1:0] p);
      logic [c_CW-1:0] d;
      d = '0;
      for (int i = 0; i <= T_LEN; i++) begin
         if (p[i] != '0) d = c_CW'(i);
      end
      return d;
   endfunction

   assign w_accept = s_valid && s_ready_q;
   assign w_fire   = (state_q == gf_pkg::ST_SEARCH) && (!m_valid_q || m_ready);
   assign w_last   = (beat_q == c_LAST_BEAT);

   // Lane k holds alpha^-(b*P+k) for the current beat b.
   for (genvar k = 0; k < ROOTS_PER_CYCLE; k++) begin : g_lane
      localparam logic [SYMB_WIDTH-1:0] c_SEED = gf_pkg::gf_alpha_pow(-k);
      logic [SYMB_WIDTH-1:0] x_q;
      logic [SYMB_WIDTH-1:0] w_val;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn)         x_q <= '0;
         else if (w_accept) x_q <= c_SEED;
         else if (w_fire)   x_q <= gf_pkg::gf_mult(x_q, c_STEP);
      end

      gf_poly_eval #(
         .T_LEN      (T_LEN),
         .SYMB_WIDTH (SYMB_WIDTH)
      ) u_eval (
         .coeff_i (lambda_q),
         .x_i     (x_q),
         .val_o   (w_val)
      );

      assign w_hit[k] = (w_val == '0) && (!w_last || (k < c_LAST_LANES));
   end

   always_comb begin
      w_pop = '0;
      for (int k = 0; k < ROOTS_PER_CYCLE; k++) begin
         w_pop = w_pop + c_CW'(w_hit[k]);
      end
      w_cnt_sum = cnt_q + w_pop;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= gf_pkg::ST_IDLE;
         s_ready_q <= 1'b1;
         lambda_q  <= '0;
         deg_q     <= '0;
         beat_q    <= '0;
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_sop_q   <= 1'b0;
         m_eop_q   <= 1'b0;
         bits_q    <= '0;
         err_cnt_q <= '0;
         fail_q    <= 1'b0;
      end else begin
         case (state_q)
            gf_pkg::ST_IDLE: begin
               // Last beat drains here; only then may a new locator be taken.
               if (m_valid_q && m_ready) begin
                  m_valid_q <= 1'b0;
                  m_sop_q   <= 1'b0;
                  m_eop_q   <= 1'b0;
                  bits_q    <= '0;
                  err_cnt_q <= '0;
                  fail_q    <= 1'b0;
                  s_ready_q <= 1'b1;
               end
               if (w_accept) begin
                  state_q   <= gf_pkg::ST_SEARCH;
                  s_ready_q <= 1'b0;
                  lambda_q  <= error_locator;
                  deg_q     <= f_degree(error_locator);
                  beat_q    <= '0;
                  cnt_q     <= '0;
               end
            end
            gf_pkg::ST_SEARCH: begin
               if (w_fire) begin
                  m_valid_q <= 1'b1;
                  m_sop_q   <= (beat_q == '0);
                  m_eop_q   <= w_last;
                  bits_q    <= w_hit;
                  cnt_q     <= w_cnt_sum;
                  beat_q    <= beat_q + 1'b1;
                  if (w_last) begin
                     err_cnt_q <= w_cnt_sum;
                     fail_q    <= (w_cnt_sum != deg_q) || (lambda_q[0] == '0);
                     state_q   <= gf_pkg::ST_IDLE;
                  end else begin
                     err_cnt_q <= '0;
                     fail_q    <= 1'b0;
                  end
               end
            end
            default: state_q <= gf_pkg::ST_IDLE;
         endcase
      end
   end

   assign s_ready       = s_ready_q;
   assign m_valid       = m_valid_q;
   assign m_sop         = m_sop_q;
   assign m_eop         = m_eop_q;
   assign error_bit_pos = bits_q;
   assign err_cnt       = err_cnt_q;
   assign fail          = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_chien_seq.sv
// +----------------------------------------------------------------------------+
// | tb_rs_chien_seq                                                             |
// | Directed self-checking bench for rs_chien_seq, GF(2^8) 0x11D, P=8, N=255.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rs_chien_seq;

   localparam int P  = 8;
   localparam int NL = 255;
   localparam int TL = 8;
   localparam int SW = 8;
   localparam int NB = 32;

   typedef logic [TL:0][SW-1:0] lam_t;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   lam_t         error_locator = '0;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic         m_sop;
   logic         m_eop;
   logic [P-1:0] error_bit_pos;
   logic [7:0]   err_cnt;
   logic         fail;

   int tests = 0;
   int fails = 0;

   logic [P-1:0] cap_bits [NB];
   logic         cap_sop  [NB];
   logic         cap_eop  [NB];
   logic [P-1:0] exp_bits [NB];
   int           cap_n;
   logic [7:0]   cap_err;
   logic         cap_fail;
   int           stall_bad;
   int           sready_bad;
   int           side_bad;

   always #5 clk = ~clk;

   rs_chien_seq #(
      .ROOTS_PER_CYCLE (P),
      .N_LEN           (NL),
      .T_LEN           (TL),
      .SYMB_WIDTH      (SW)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .error_locator (error_locator),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_sop         (m_sop),
      .m_eop         (m_eop),
      .error_bit_pos (error_bit_pos),
      .err_cnt       (err_cnt),
      .fail          (fail)
   );

   // Offers one locator, then records accepted beats (all sampled on negedge).
   task automatic run_cw(input lam_t lam, input bit rnd, input int max_beats);
      int           n;
      bit           done;
      logic         pv, pr, ps, pe, pf;
      logic [P-1:0] pb;
      logic [7:0]   pc;
      cap_n = 0; stall_bad = 0; sready_bad = 0; side_bad = 0;
      cap_err = '0; cap_fail = 1'b0; done = 1'b0;
      pv = 1'b0; pr = 1'b1; ps = 1'b0; pe = 1'b0; pf = 1'b0; pb = '0; pc = '0;
      for (int i = 0; i < NB; i++) begin
         cap_bits[i] = '0; cap_sop[i] = 1'b0; cap_eop[i] = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      error_locator = lam;
      n = 0;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      s_valid = 1'b0;
      n = 0;
      while (!done && cap_n < max_beats && n < 3000) begin
         if (pv && !pr &&
             ({m_valid, m_sop, m_eop, error_bit_pos, err_cnt, fail} !== {pv, ps, pe, pb, pc, pf}))
            stall_bad++;
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_valid) begin
            if (s_ready) sready_bad++;
            if (!m_eop && (err_cnt != 8'd0 || fail)) side_bad++;
            if (m_ready) begin
               if (cap_n < NB) begin
                  cap_bits[cap_n] = error_bit_pos;
                  cap_sop[cap_n]  = m_sop;
                  cap_eop[cap_n]  = m_eop;
               end
               if (m_eop) begin
                  cap_err  = err_cnt;
                  cap_fail = fail;
                  done     = 1'b1;
               end
               cap_n++;
            end
         end
         pv = m_valid; pr = m_ready; ps = m_sop; pe = m_eop; pb = error_bit_pos; pc = err_cnt; pf = fail;
         @(negedge clk);
         n++;
      end
      m_ready = 1'b1;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < NB; i++) exp_bits[i] = '0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if ({s_ready, m_valid, m_sop, m_eop} !== 4'b1000) begin
         fails++;
         $display("FAIL reset_ctrl: got rdy/val/sop/eop=%b, required 1000", {s_ready, m_valid, m_sop, m_eop});
      end
      tests++;
      if ({error_bit_pos, err_cnt, fail} !== 17'd0) begin
         fails++;
         $display("FAIL reset_data: got bits=%h cnt=%0d fail=%b, required 0", error_bit_pos, err_cnt, fail);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_no_error();
      int   nbad;
      lam_t lam;
      lam = '0; lam[0] = 8'h01;
      clear_exp();
      run_cw(lam, 1'b0, NB);
      tests++;
      if (cap_n !== NB) begin fails++; $display("FAIL t1_beats: got %0d beats, required %0d", cap_n, NB); end
      nbad = 0;
      for (int i = 0; i < NB; i++)
         if (cap_bits[i] !== exp_bits[i] || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == NB - 1)) nbad++;
      tests++;
      if (nbad != 0) begin fails++; $display("FAIL t1_stream: %0d beats wrong, required 0", nbad); end
      tests++;
      if ({cap_err, cap_fail} !== {8'd0, 1'b0}) begin
         fails++; $display("FAIL t1_status: got cnt=%0d fail=%b, required 0/0", cap_err, cap_fail);
      end
      tests++;
      if (side_bad != 0) begin fails++; $display("FAIL t1_sideband: %0d non-eop beats with status, required 0", side_bad); end
   endtask

   task automatic test_single_root();
      int   nbad;
      lam_t lam;
      lam = '0; lam[0] = 8'h01; lam[1] = 8'h20;
      clear_exp(); exp_bits[0] = 8'h20;
      run_cw(lam, 1'b0, NB);
      tests++;
      if (cap_bits[0] !== 8'h20) begin fails++; $display("FAIL t2_beat0: got %h, required 20", cap_bits[0]); end
      nbad = 0;
      for (int i = 0; i < NB; i++)
         if (cap_bits[i] !== exp_bits[i] || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == NB - 1)) nbad++;
      tests++;
      if (nbad != 0 || cap_n !== NB) begin fails++; $display("FAIL t2_stream: %0d beats wrong of %0d, required 0 of 32", nbad, cap_n); end
      tests++;
      if ({cap_err, cap_fail} !== {8'd1, 1'b0}) begin
         fails++; $display("FAIL t2_status: got cnt=%0d fail=%b, required 1/0", cap_err, cap_fail);
      end
   endtask

   task automatic test_edge_roots(input bit rnd);
      int   nbad;
      lam_t lam;
      lam = '0; lam[0] = 8'h01; lam[1] = 8'h8F; lam[2] = 8'h8E;
      clear_exp(); exp_bits[0] = 8'h01; exp_bits[31] = 8'h40;
      run_cw(lam, rnd, NB);
      tests++;
      if (cap_bits[31] !== 8'h40) begin fails++; $display("FAIL t3_beat31: got %h, required 40", cap_bits[31]); end
      nbad = 0;
      for (int i = 0; i < NB; i++)
         if (cap_bits[i] !== exp_bits[i] || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == NB - 1)) nbad++;
      tests++;
      if (nbad != 0 || cap_n !== NB) begin fails++; $display("FAIL t3_stream rnd=%0d: %0d beats wrong of %0d, required 0 of 32", rnd, nbad, cap_n); end
      tests++;
      if ({cap_err, cap_fail} !== {8'd2, 1'b0}) begin
         fails++; $display("FAIL t3_status rnd=%0d: got cnt=%0d fail=%b, required 2/0", rnd, cap_err, cap_fail);
      end
      if (rnd) begin
         tests++;
         if (stall_bad != 0) begin fails++; $display("FAIL t5_stall_hold: %0d unstable stalled cycles, required 0", stall_bad); end
         tests++;
         if (sready_bad != 0) begin fails++; $display("FAIL t5_sready_busy: %0d beats with s_ready=1, required 0", sready_bad); end
         tests++;
         if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            fails++; $display("FAIL t5_drain: got s_ready=%b m_valid=%b, required 1/0", s_ready, m_valid);
         end
      end
   endtask

   task automatic test_subfield_roots();
      int   nbad;
      lam_t lam;
      lam = '0; lam[0] = 8'h01; lam[1] = 8'h01; lam[2] = 8'h01;
      clear_exp(); exp_bits[10] = 8'h20; exp_bits[21] = 8'h04;
      run_cw(lam, 1'b0, NB);
      nbad = 0;
      for (int i = 0; i < NB; i++)
         if (cap_bits[i] !== exp_bits[i] || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == NB - 1)) nbad++;
      tests++;
      if (nbad != 0 || cap_n !== NB) begin fails++; $display("FAIL t4_stream: %0d beats wrong of %0d, required 0 of 32", nbad, cap_n); end
      tests++;
      if ({cap_err, cap_fail} !== {8'd2, 1'b0}) begin
         fails++; $display("FAIL t4_status: got cnt=%0d fail=%b, required 2/0", cap_err, cap_fail);
      end
   endtask

   task automatic test_fail_cases();
      lam_t lam;
      // 1+x^2 = (1+x)^2: one in-range root, degree 2
      lam = '0; lam[0] = 8'h01; lam[2] = 8'h01;
      run_cw(lam, 1'b0, NB);
      tests++;
      if ({cap_bits[0], cap_bits[31], cap_err, cap_fail} !== {8'h01, 8'h00, 8'd1, 1'b1}) begin
         fails++; $display("FAIL t4b_short: got b0=%h b31=%h cnt=%0d fail=%b, required 01/00/1/1",
                           cap_bits[0], cap_bits[31], cap_err, cap_fail);
      end
      lam = '0;
      run_cw(lam, 1'b0, NB);
      tests++;
      if ({cap_bits[0], cap_bits[15], cap_bits[31], cap_err, cap_fail} !== {8'hFF, 8'hFF, 8'h7F, 8'd255, 1'b1}) begin
         fails++; $display("FAIL zero_lambda: got b0=%h b15=%h b31=%h cnt=%0d fail=%b, required FF/FF/7F/255/1",
                           cap_bits[0], cap_bits[15], cap_bits[31], cap_err, cap_fail);
      end
      lam = '0; lam[1] = 8'h01;
      run_cw(lam, 1'b0, NB);
      tests++;
      if ({cap_err, cap_fail} !== {8'd0, 1'b1} || cap_n !== NB) begin
         fails++; $display("FAIL const_zero: got cnt=%0d fail=%b beats=%0d, required 0/1/32", cap_err, cap_fail, cap_n);
      end
   endtask

   task automatic test_mid_reset();
      int   nbad;
      lam_t lam;
      lam = '0; lam[0] = 8'h01; lam[1] = 8'h8F; lam[2] = 8'h8E;
      run_cw(lam, 1'b0, 12);
      tests++;
      if (cap_n !== 12) begin fails++; $display("FAIL t6_prefix: got %0d beats, required 12", cap_n); end
      rstn = 1'b0;
      #1;
      tests++;
      if ({s_ready, m_valid, m_sop, m_eop, error_bit_pos, err_cnt, fail} !== {1'b1, 20'd0}) begin
         fails++; $display("FAIL t6_async_reset: got rdy=%b val=%b sop=%b eop=%b bits=%h cnt=%0d fail=%b, required 1 and rest 0",
                           s_ready, m_valid, m_sop, m_eop, error_bit_pos, err_cnt, fail);
      end
      @(negedge clk);
      rstn = 1'b1;
      lam = '0; lam[0] = 8'h01; lam[1] = 8'h20;
      clear_exp(); exp_bits[0] = 8'h20;
      run_cw(lam, 1'b0, NB);
      nbad = 0;
      for (int i = 0; i < NB; i++)
         if (cap_bits[i] !== exp_bits[i] || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == NB - 1)) nbad++;
      tests++;
      if (nbad != 0 || cap_n !== NB || {cap_err, cap_fail} !== {8'd1, 1'b0}) begin
         fails++; $display("FAIL t6_recover: %0d beats wrong of %0d cnt=%0d fail=%b, required 0 of 32 1/0",
                           nbad, cap_n, cap_err, cap_fail);
      end
   endtask

   initial begin
      test_reset();
      test_no_error();
      test_single_root();
      test_edge_roots(1'b0);
      test_subfield_roots();
      test_fail_cases();
      test_edge_roots(1'b1);
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
